// File: rtl/gpu_pkg.sv
// Shared encodings and default widths for the core pipeline blocks.
// The fetch stage uses the scheduler states and its own progress codes.
package gpu_pkg;

  localparam int PROGRAM_MEM_ADDR_BITS_DEF = 8;
  localparam int PROGRAM_MEM_DATA_BITS_DEF = 16;
  localparam int MISS_CNT_BITS_DEF         = 16;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Valid/ready read channel between the fetch stage and the program-memory
// controller; the fetch stage is the master.
interface fetch_unit_if
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEF,
  parameter int DATA_BITS = PROGRAM_MEM_DATA_BITS_DEF
);

  logic                 read_valid;
  logic [ADDR_BITS-1:0] read_address;
  logic                 read_ready;
  logic [DATA_BITS-1:0] read_data;

  modport master (
    output read_valid,
    output read_address,
    input  read_ready,
    input  read_data
  );

  modport slave (
    input  read_valid,
    input  read_address,
    output read_ready,
    output read_data
  );

endinterface

// File: rtl/fetch_line_buf.sv
// One-entry last-fetch buffer: combinational lookup, install of a completed
// fetch, and flush tracking so a flushed in-flight response is never cached.
module fetch_line_buf
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEF,
  parameter int DATA_BITS = PROGRAM_MEM_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_pc,
  output logic                 hit,
  output logic [DATA_BITS-1:0] lookup_instr,
  input  logic                 in_flight,
  input  logic                 install,
  input  logic [ADDR_BITS-1:0] install_pc,
  input  logic [DATA_BITS-1:0] install_instr,
  input  logic                 flush
);

  logic                 buf_valid;
  logic                 flush_pending;
  logic [ADDR_BITS-1:0] buf_pc;
  logic [DATA_BITS-1:0] buf_instr;
  logic                 install_ok;

  // A flush on the completing edge counts as seen, so that response is not kept.
  assign install_ok   = install && !flush_pending && !flush;
  assign hit          = buf_valid && (buf_pc == lookup_pc) && !flush;
  assign lookup_instr = buf_instr;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid     <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      if (flush)
        buf_valid <= 1'b0;
      else if (install_ok)
        buf_valid <= 1'b1;

      if (install)
        flush_pending <= 1'b0;
      else if (in_flight && flush)
        flush_pending <= 1'b1;
    end
  end

  // NOTE: the payload has no reset; buf_valid alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (install_ok) begin
      buf_pc    <= install_pc;
      buf_instr <= install_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: serves the PC from the last-fetch buffer on a hit,
// otherwise issues one read to program memory and waits for its response.
module fetch_unit
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEF,
  parameter int PROGRAM_MEM_DATA_BITS = PROGRAM_MEM_DATA_BITS_DEF,
  parameter int MISS_CNT_BITS         = MISS_CNT_BITS_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  fetch_unit_if.master                     mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [MISS_CNT_BITS-1:0]         miss_count
);

  fetcher_state_e                   state_q, state_d;
  logic                             valid_q, valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
  logic [MISS_CNT_BITS-1:0]         cnt_q, cnt_d;

  logic                             hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] hit_instr;
  logic                             in_flight;
  logic                             install;

  assign in_flight = (state_q == FETCHER_FETCHING);
  assign install   = in_flight && mem.read_ready;

  fetch_line_buf #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS)
  ) u_line_buf (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (current_pc),
    .hit           (hit),
    .lookup_instr  (hit_instr),
    .in_flight     (in_flight),
    .install       (install),
    .install_pc    (addr_q),
    .install_instr (mem.read_data),
    .flush         (flush)
  );

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (hit) begin
            instr_d = hit_instr;
            state_d = FETCHER_FETCHED;
          end else begin
            valid_d = 1'b1;
            addr_d  = current_pc;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            state_d = FETCHER_FETCHING;
          end
        end
      end
      FETCHER_FETCHING: begin
        if (mem.read_ready) begin
          instr_d = mem.read_data;
          valid_d = 1'b0;
          state_d = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE)
          state_d = FETCHER_IDLE;
      end
      default: state_d = FETCHER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCHER_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign miss_count       = cnt_q;
  assign mem.read_valid   = valid_q;
  assign mem.read_address = addr_q;

  // A pending request keeps its address until the controller accepts it.
  a_req_stable: assert property (@(posedge clk) disable iff (!reset)
    (mem.read_valid && !mem.read_ready) |=> (mem.read_valid && $stable(mem.read_address)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios plus
// randomized fetch/flush/latency traffic compared against a behavioural model.
module tb_fetch_unit;
  import gpu_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    core_state = 3'b000;
  logic [AW-1:0] current_pc = '0;
  logic          flush = 1'b0;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;
  logic [CW-1:0] miss_count;

  fetch_unit_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) mif ();

  fetch_unit #(
    .PROGRAM_MEM_ADDR_BITS (AW),
    .PROGRAM_MEM_DATA_BITS (DW),
    .MISS_CNT_BITS         (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .flush         (flush),
    .mem           (mif.master),
    .fetcher_state (fetcher_state),
    .instruction   (instruction),
    .miss_count    (miss_count)
  );

  // Second instance with a 2-bit counter; its memory answers immediately.
  logic [2:0]    sat_core_state = 3'b000;
  logic [AW-1:0] sat_pc = '0;
  logic          sat_flush = 1'b0;
  logic [2:0]    sat_fstate;
  logic [DW-1:0] sat_instr;
  logic [1:0]    sat_cnt;

  fetch_unit_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) sif ();
  assign sif.read_ready = sif.read_valid;
  assign sif.read_data  = {8'hC0, sif.read_address};

  fetch_unit #(
    .PROGRAM_MEM_ADDR_BITS (AW),
    .PROGRAM_MEM_DATA_BITS (DW),
    .MISS_CNT_BITS         (2)
  ) dut_sat (
    .clk           (clk),
    .reset         (reset),
    .core_state    (sat_core_state),
    .current_pc    (sat_pc),
    .flush         (sat_flush),
    .mem           (sif.master),
    .fetcher_state (sat_fstate),
    .instruction   (sat_instr),
    .miss_count    (sat_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder and flush driver, acting 2 time units after each edge.
  logic [DW-1:0] mem_tbl [256];
  int  lat_fix     = 1;
  bit  rand_lat    = 1'b0;
  bit  stray_en    = 1'b0;
  bit  flush_rand  = 1'b0;
  bit  force_ready = 1'b0;
  bit  force_flush = 1'b0;
  int  flush_at    = 0;
  int  cnt         = 0;
  int  cur_lat     = 1;

  initial begin
    mif.read_ready = 1'b0;
    mif.read_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset && mif.read_valid) begin
        cnt++;
        if (cnt == 1) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat_fix;
        mif.read_ready = (cnt >= cur_lat);
        mif.read_data  = (cnt >= cur_lat) ? mem_tbl[mif.read_address] : DW'($urandom);
      end else begin
        cnt = 0;
        mif.read_ready = force_ready || (stray_en && $urandom_range(0, 5) == 0);
        mif.read_data  = DW'($urandom);
      end
      flush = force_flush || (flush_at != 0 && cnt == flush_at) ||
              (flush_rand && $urandom_range(0, 9) == 0);
    end
  end

  // Behavioural model of the fetch stage: what the core should observe.
  logic [2:0]    m_state = 3'b000;
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_instr = '0;
  logic [CW-1:0] m_cnt   = '0;
  logic          m_bv    = 1'b0;
  logic [AW-1:0] m_bpc   = '0;
  logic [DW-1:0] m_binstr = '0;
  logic          m_fseen = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state <= 3'b000;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_instr <= '0;
      m_cnt   <= '0;
      m_bv    <= 1'b0;
      m_fseen <= 1'b0;
    end else begin
      if (m_state == 3'b000 && core_state == 3'b001) begin
        if (m_bv && m_bpc == current_pc && !flush) begin
          m_instr <= m_binstr;
          m_state <= 3'b010;
        end else begin
          m_valid <= 1'b1;
          m_addr  <= current_pc;
          if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
          m_fseen <= 1'b0;
          m_state <= 3'b001;
        end
      end else if (m_state == 3'b001) begin
        if (mif.read_ready) begin
          m_instr <= mif.read_data;
          m_valid <= 1'b0;
          if (!m_fseen && !flush) begin
            m_bv     <= 1'b1;
            m_bpc    <= m_addr;
            m_binstr <= mif.read_data;
          end
          m_state <= 3'b010;
        end else if (flush) begin
          m_fseen <= 1'b1;
        end
      end else if (m_state == 3'b010 && core_state == 3'b010) begin
        m_state <= 3'b000;
      end
      if (flush) m_bv <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("state", 32'(fetcher_state), 32'(m_state));
    check("valid", 32'(mif.read_valid), 32'(m_valid));
    if (m_valid) check("address", 32'(mif.read_address), 32'(m_addr));
    check("instruction", 32'(instruction), 32'(m_instr));
    check("miss_count", 32'(miss_count), 32'(m_cnt));
  end

  // Request monitor.
  int req_rises    = 0;
  int valid_cycles = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (mif.read_valid && !prev_v) req_rises++;
    if (mif.read_valid) valid_cycles++;
    prev_v = mif.read_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [AW-1:0] pc, input int dwell, output int lat);
    logic [2:0] v;
    core_state = CORE_FETCH;
    current_pc = pc;
    tick();
    core_state = CORE_WAIT;
    current_pc = AW'($urandom);
    lat = 1;
    while (fetcher_state != FETCHER_FETCHED && lat < 60) begin
      tick();
      lat++;
    end
    if (lat >= 60) check("fetch_timeout", 32'(fetcher_state), 32'(FETCHER_FETCHED));
    for (int d = 0; d < dwell; d++) begin
      v = 3'($urandom_range(0, 7));
      core_state = (v == 3'b010) ? 3'b001 : v;
      tick();
    end
    core_state = CORE_DECODE;
    tick();
    core_state = CORE_IDLE;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0, v0;
    logic [1:0] exp_sat;
    for (int i = 0; i < 256; i++) mem_tbl[i] = DW'($urandom);
    mem_tbl[8'h05] = 16'h1234;
    mem_tbl[8'h06] = 16'hA5A5;
    mem_tbl[8'h10] = 16'hBEEF;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_state", 32'(fetcher_state), 32'h0);
    check("reset_valid", 32'(mif.read_valid), 32'h0);
    check("reset_address", 32'(mif.read_address), 32'h0);
    check("reset_instr", 32'(instruction), 32'h0);
    check("reset_miss", 32'(miss_count), 32'h0);

    // Cold miss, ready in the third valid cycle.
    lat_fix = 3;
    r0 = req_rises; v0 = valid_cycles;
    do_fetch(8'h05, 0, lat);
    check("cold_latency", 32'(lat), 32'd4);
    check("cold_requests", 32'(req_rises - r0), 32'd1);
    check("cold_valid_cycles", 32'(valid_cycles - v0), 32'd3);
    check("cold_instr", 32'(instruction), 32'h1234);
    check("cold_miss", 32'(miss_count), 32'd1);

    // Repeat fetch served from the buffer.
    r0 = req_rises;
    do_fetch(8'h05, 1, lat);
    check("hit_latency", 32'(lat), 32'd1);
    check("hit_requests", 32'(req_rises - r0), 32'd0);
    check("hit_instr", 32'(instruction), 32'h1234);
    check("hit_miss", 32'(miss_count), 32'd1);

    // Branch-loop alternation from an empty buffer.
    force_flush = 1'b1;
    tick();
    force_flush = 1'b0;
    lat_fix = 1;
    r0 = req_rises;
    do_fetch(8'h05, 0, lat);
    check("first_cycle_ready_latency", 32'(lat), 32'd2);
    do_fetch(8'h06, 0, lat);
    check("loop_instr_06", 32'(instruction), 32'hA5A5);
    do_fetch(8'h05, 0, lat);
    check("loop_requests", 32'(req_rises - r0), 32'd3);
    check("loop_miss", 32'(miss_count), 32'd4);
    r0 = req_rises;
    do_fetch(8'h05, 0, lat);
    check("loop_buf_hit_latency", 32'(lat), 32'd1);
    check("loop_buf_hit_requests", 32'(req_rises - r0), 32'd0);

    // Flush while the request is outstanding.
    lat_fix = 4;
    flush_at = 2;
    do_fetch(8'h10, 0, lat);
    flush_at = 0;
    check("flush_instr", 32'(instruction), 32'hBEEF);
    r0 = req_rises;
    do_fetch(8'h10, 0, lat);
    check("flush_refetch_requests", 32'(req_rises - r0), 32'd1);

    // Reset while fetching, then a late ready.
    lat_fix = 20;
    core_state = CORE_FETCH;
    current_pc = 8'h22;
    tick();
    core_state = CORE_WAIT;
    tick();
    tick();
    check("midfetch_valid", 32'(mif.read_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("reset_async_valid", 32'(mif.read_valid), 32'h0);
    check("reset_async_state", 32'(fetcher_state), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    tick();
    tick();
    check("late_ready_state", 32'(fetcher_state), 32'h0);
    check("late_ready_valid", 32'(mif.read_valid), 32'h0);
    check("late_ready_miss", 32'(miss_count), 32'h0);
    core_state = CORE_IDLE;

    // Randomized traffic checked cycle by cycle against the model.
    rand_lat = 1'b1; stray_en = 1'b1; flush_rand = 1'b1;
    for (int n = 0; n < 150; n++)
      do_fetch(AW'($urandom_range(0, 7)), int'($urandom_range(0, 3)), lat);
    rand_lat = 1'b0; stray_en = 1'b0; flush_rand = 1'b0;
    tick();

    // Miss counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      sat_core_state = CORE_FETCH;
      sat_pc = AW'(8'h40 + i);
      tick();
      sat_core_state = CORE_WAIT;
      tick();
      tick();
      exp_sat = (i >= 2) ? 2'd3 : 2'(i + 1);
      check("sat_state", 32'(sat_fstate), 32'(FETCHER_FETCHED));
      check("sat_instr", 32'(sat_instr), 32'(16'hC040 + i));
      check("sat_miss", 32'(sat_cnt), 32'(exp_sat));
      sat_core_state = CORE_DECODE;
      tick();
      sat_core_state = CORE_IDLE;
    end

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
